regfile_sb: RTL and testbench

- Parametrised successor to the core's integer register file: generic width and depth, hardwired-zero register 0, two combinational read ports.
- Adds a per-register scoreboard (busy bits): a decoder marks destinations at issue, and writeback clears them. The pipeline uses this to stall on RAW hazards.
- Adds a sequential clear engine after reset: registers are zeroed one per cycle, and `ready` is held low until clearing is done.
- Sits between decode/issue and writeback in the pipelined core.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 44 ++++
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file and its scoreboard.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int ZERO_REG = 0;

  function automatic int addr_bits(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets a bit and writeback clears it, with issue winning on a collision.
// Flags a writeback to a non-busy register one cycle later. There is no backpressure.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = addr_bits(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_rd_addr,
  input  logic             write_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [NREGS-1:0] busy,
  output logic             wb_unexpected
);

  logic             wb_hit;
  logic             iss_hit;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    wb_hit   = run && write_en && (rd_addr != AW'(ZERO_REG));
    iss_hit  = run && issue_en && (issue_rd_addr != AW'(ZERO_REG));
    busy_nxt = busy;
    if (wb_hit) busy_nxt[rd_addr] = 1'b0;
    // The set is applied after the clear, so the new producer keeps ownership.
    if (iss_hit) busy_nxt[issue_rd_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      wb_unexpected <= 1'b0;
    end else begin
      busy          <= busy_nxt;
      wb_unexpected <= wb_hit && !busy[rd_addr];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard and a post-reset clear engine (ready low for NREGS-1 cycles).
// Reads are combinational; REGFILE_BYPASS_EN forwards same-cycle writeback to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = addr_bits(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd_addr,
  input  logic            write_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wb_unexpected
);

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    clr_idx;
  logic [AW-1:0]    clr_idx_nxt;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             run;
  logic             wr_hit;

  assign run    = (state == RUN);
  assign ready  = run;
  assign wr_hit = run && write_en && (rd_addr != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    if (state == CLEAR) begin
      clr_idx_nxt = clr_idx + AW'(1);
      if (clr_idx == AW'(NREGS - 1)) state_nxt = RUN;
    end
  end

  // Contents survive rst; only the clear engine zeroes them. Register 0 is never stored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) regs[clr_idx] <= '0;
      else if (wr_hit)    regs[rd_addr] <= rd_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .issue_en      (issue_en),
    .issue_rd_addr (issue_rd_addr),
    .write_en      (write_en),
    .rd_addr       (rd_addr),
    .busy          (busy),
    .wb_unexpected (wb_unexpected)
  );

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_addr != AW'(ZERO_REG)) begin
      if (!run) begin
        rs1_busy = 1'b1;
      end else begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (rd_addr == rs1_addr)) begin
          rs1_data = rd_data;
          rs1_busy = issue_en && (issue_rd_addr == rs1_addr);
        end
`endif
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_addr != AW'(ZERO_REG)) begin
      if (!run) begin
        rs2_busy = 1'b1;
      end else begin
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (rd_addr == rs2_addr)) begin
          rs2_data = rd_data;
          rs2_busy = issue_en && (issue_rd_addr == rs2_addr);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: expected register contents are queued when writes are driven.
module tb_regfile_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic            issue_en;
  logic [AW-1:0]   issue_rd_addr;
  logic            write_en;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            wb_unexpected;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk           (clk),
    .rst           (rst),
    .ready         (ready),
    .issue_en      (issue_en),
    .issue_rd_addr (issue_rd_addr),
    .write_en      (write_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .wb_unexpected (wb_unexpected)
  );

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en      = 1'b0;
    issue_rd_addr = '0;
    write_en      = 1'b0;
    rd_addr       = '0;
    rd_data       = '0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!ready && cyc < 200);
  endtask

  task automatic test_reset();
    int   cyc;
    exp_t e;
    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    wait_ready(cyc);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL init_ready: got %b exp 1", ready); end
    for (int i = 1; i < NREGS; i++) begin
      write_en = 1'b1;
      rd_addr  = AW'(i);
      rd_data  = {32'hA5A5_0000, 32'(i)};
      tick();
    end
    idle();
    exp_q.push_back('{addr: AW'(17), data: {32'hA5A5_0000, 32'd17}, busy: 1'b0});
    e = exp_q.pop_front();
    rs1_addr = e.addr;
    #1;
    tests++; if (rs1_data !== e.data) begin fails++; $display("FAIL fill_data: got %h exp %h", rs1_data, e.data); end
    rst = 1'b1;
    tick();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b exp 0", ready); end
    tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL rst_wbu: got %b exp 0", wb_unexpected); end
    rst = 1'b0;
    #1;
    tests++; if (rs1_busy !== 1'b1 || rs1_data !== '0) begin fails++; $display("FAIL clear_read: got busy %b data %h exp 1/0", rs1_busy, rs1_data); end
    wait_ready(cyc);
    tests++; if (cyc !== NREGS - 1) begin fails++; $display("FAIL clear_cycles: got %0d exp %0d", cyc, NREGS - 1); end
    for (int i = 0; i < NREGS; i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(NREGS - 1 - i);
      #1;
      tests++; if (rs1_data !== '0 || rs1_busy !== 1'b0) begin fails++; $display("FAIL cleared_rs1[%0d]: got %h/%b exp 0/0", i, rs1_data, rs1_busy); end
      tests++; if (rs2_data !== '0 || rs2_busy !== 1'b0) begin fails++; $display("FAIL cleared_rs2[%0d]: got %h/%b exp 0/0", NREGS - 1 - i, rs2_data, rs2_busy); end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    rs1_addr      = AW'(5);
    issue_en      = 1'b1;
    issue_rd_addr = AW'(5);
    #1;
    tests++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL sb_pre_issue: got %b exp 0", rs1_busy); end
    tick();
    idle();
    tests++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL sb_issued: got %b exp 1", rs1_busy); end
    tick();
    tests++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL sb_still_busy: got %b exp 1", rs1_busy); end
    write_en = 1'b1;
    rd_addr  = AW'(5);
    rd_data  = 64'hDEAD_BEEF_0000_0001;
    exp_q.push_back('{addr: AW'(5), data: 64'hDEAD_BEEF_0000_0001, busy: 1'b0});
    #1;
`ifdef REGFILE_BYPASS_EN
    tests++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL sb_wb_cycle_busy: got %b exp 0", rs1_busy); end
`else
    tests++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL sb_wb_cycle_busy: got %b exp 1", rs1_busy); end
`endif
    tick();
    idle();
    e = exp_q.pop_front();
    rs1_addr = e.addr;
    #1;
    tests++; if (rs1_data !== e.data || rs1_busy !== e.busy) begin fails++; $display("FAIL sb_written: got %h/%b exp %h/%b", rs1_data, rs1_busy, e.data, e.busy); end
    tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL sb_wbu: got %b exp 0", wb_unexpected); end
  endtask

  task automatic test_collision();
    exp_t e;
    rs1_addr      = AW'(7);
    issue_en      = 1'b1;
    issue_rd_addr = AW'(7);
    tick();
    idle();
    tests++; if (rs1_busy !== 1'b1) begin fails++; $display("FAIL col_busy: got %b exp 1", rs1_busy); end
    issue_en      = 1'b1;
    issue_rd_addr = AW'(7);
    write_en      = 1'b1;
    rd_addr       = AW'(7);
    rd_data       = 64'h42;
    exp_q.push_back('{addr: AW'(7), data: 64'h42, busy: 1'b1});
    tick();
    idle();
    e = exp_q.pop_front();
    rs1_addr = e.addr;
    #1;
    tests++; if (rs1_data !== e.data || rs1_busy !== e.busy) begin fails++; $display("FAIL col_same_edge: got %h/%b exp %h/%b", rs1_data, rs1_busy, e.data, e.busy); end
    tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL col_wbu: got %b exp 0", wb_unexpected); end
    write_en = 1'b1;
    rd_addr  = AW'(7);
    rd_data  = 64'h43;
    exp_q.push_back('{addr: AW'(7), data: 64'h43, busy: 1'b0});
    tick();
    idle();
    e = exp_q.pop_front();
    rs1_addr = e.addr;
    #1;
    tests++; if (rs1_data !== e.data || rs1_busy !== e.busy) begin fails++; $display("FAIL col_release: got %h/%b exp %h/%b", rs1_data, rs1_busy, e.data, e.busy); end
    tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL col_release_wbu: got %b exp 0", wb_unexpected); end
  endtask

  task automatic test_x0_unexpected();
    exp_t e;
    rs1_addr      = '0;
    rs2_addr      = '0;
    write_en      = 1'b1;
    rd_addr       = '0;
    rd_data       = 64'hFFFF;
    issue_en      = 1'b1;
    issue_rd_addr = '0;
    #1;
    tests++; if (rs1_data !== '0 || rs1_busy !== 1'b0) begin fails++; $display("FAIL x0_same_cycle: got %h/%b exp 0/0", rs1_data, rs1_busy); end
    tick();
    idle();
    tests++; if (rs2_data !== '0 || rs2_busy !== 1'b0) begin fails++; $display("FAIL x0_after: got %h/%b exp 0/0", rs2_data, rs2_busy); end
    tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL x0_wbu: got %b exp 0", wb_unexpected); end
    write_en = 1'b1;
    rd_addr  = AW'(9);
    rd_data  = 64'h0909_0909_0909_0909;
    exp_q.push_back('{addr: AW'(9), data: 64'h0909_0909_0909_0909, busy: 1'b0});
    tick();
    idle();
    tests++; if (wb_unexpected !== 1'b1) begin fails++; $display("FAIL wbu_pulse: got %b exp 1", wb_unexpected); end
    e = exp_q.pop_front();
    rs1_addr = e.addr;
    #1;
    tests++; if (rs1_data !== e.data) begin fails++; $display("FAIL wbu_data: got %h exp %h", rs1_data, e.data); end
    tick();
    tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL wbu_one_cycle: got %b exp 0", wb_unexpected); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    write_en = 1'b1;
    rd_addr  = AW'(3);
    rd_data  = 64'h55;
    tick();
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    write_en      = 1'b1;
    rd_addr       = AW'(3);
    rd_data       = 64'hAAAA;
    issue_en      = 1'b1;
    issue_rd_addr = AW'(4);
    rs1_addr      = AW'(3);
    rs2_addr      = AW'(4);
    repeat (10) tick();
    tests++; if (ready !== 1'b0 || rs2_busy !== 1'b1) begin fails++; $display("FAIL midclr_state: got ready %b busy %b exp 0/1", ready, rs2_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(cyc);
    idle();
    #1;
    tests++; if (cyc !== NREGS - 1) begin fails++; $display("FAIL midclr_cycles: got %0d exp %0d", cyc, NREGS - 1); end
    tests++; if (rs1_data !== '0 || rs1_busy !== 1'b0) begin fails++; $display("FAIL clr_ignores_wr: got %h/%b exp 0/0", rs1_data, rs1_busy); end
    tests++; if (rs2_busy !== 1'b0) begin fails++; $display("FAIL clr_ignores_issue: got %b exp 0", rs2_busy); end
    tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL clr_wbu: got %b exp 0", wb_unexpected); end
  endtask

  task automatic test_bypass();
    exp_t e;
    rs2_addr = AW'(3);
    write_en = 1'b1;
    rd_addr  = AW'(3);
    rd_data  = 64'h1234;
    exp_q.push_back('{addr: AW'(3), data: 64'h1234, busy: 1'b0});
    #1;
`ifdef REGFILE_BYPASS_EN
    tests++; if (rs2_data !== 64'h1234 || rs2_busy !== 1'b0) begin fails++; $display("FAIL byp_same_cycle: got %h/%b exp 1234/0", rs2_data, rs2_busy); end
`else
    tests++; if (rs2_data !== '0 || rs2_busy !== 1'b0) begin fails++; $display("FAIL byp_same_cycle: got %h/%b exp 0/0", rs2_data, rs2_busy); end
`endif
    tick();
    idle();
    e = exp_q.pop_front();
    rs2_addr = e.addr;
    #1;
    tests++; if (rs2_data !== e.data || rs2_busy !== e.busy) begin fails++; $display("FAIL byp_next_cycle: got %h/%b exp %h/%b", rs2_data, rs2_busy, e.data, e.busy); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i <= 8; i++) begin
      idle();
      if (i < 8) begin
        issue_en      = 1'b1;
        issue_rd_addr = AW'(10 + i);
      end
      if (i > 0) begin
        write_en = 1'b1;
        rd_addr  = AW'(9 + i);
        rd_data  = 64'hB0B0_0000_0000_0000 | 64'($urandom_range(1, 65535));
        exp_q.push_back('{addr: AW'(9 + i), data: rd_data, busy: 1'b0});
      end
      tick();
      tests++; if (wb_unexpected !== 1'b0) begin fails++; $display("FAIL b2b_wbu[%0d]: got %b exp 0", i, wb_unexpected); end
    end
    idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rs1_addr = e.addr;
      rs2_addr = e.addr;
      #1;
      tests++; if (rs1_data !== e.data || rs1_busy !== e.busy) begin fails++; $display("FAIL b2b_rs1[%0d]: got %h/%b exp %h/%b", e.addr, rs1_data, rs1_busy, e.data, e.busy); end
      tests++; if (rs2_data !== e.data || rs2_busy !== e.busy) begin fails++; $display("FAIL b2b_rs2[%0d]: got %h/%b exp %h/%b", e.addr, rs2_data, rs2_busy, e.data, e.busy); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs1_addr = '0;
    rs2_addr = '0;
    test_reset();
    test_scoreboard();
    test_collision();
    test_x0_unexpected();
    test_mid_reset();
    test_bypass();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
